// File: rtl/serial_subtractor_ctrl.sv
// Serial subtractor controller: computes A - B - Bin one bit per cycle, LSB first,
// through a single shared 1-bit full-subtractor cell.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borr
);
  // state | meaning
  // IDLE  | waiting for start; last result held on Diff/Borr
  // RUN   | one operand bit pair consumed per cycle, LSB first
  // DONE  | one-cycle done pulse, then unconditional return to IDLE

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] part_shift;
  logic             r_q, r_d;
  logic             borr_q, borr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cell_d;
  logic             cell_r;
  logic             last_bit;

  assign cell_d   = a_q[0] ^ b_q[0] ^ r_q;
  assign cell_r   = (~a_q[0] & b_q[0]) | (~a_q[0] & r_q) | (b_q[0] & r_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    part_d     = part_q;
    diff_d     = diff_q;
    borr_d     = borr_q;
    // New result bit enters at the MSB so that after WIDTH shifts bit 0 holds the LSB.
    part_shift = part_q >> 1;
    part_shift[WIDTH-1] = cell_d;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          r_d     = Bin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        r_d    = cell_r;
        cnt_d  = cnt_q + 1'b1;
        part_d = part_shift;
        if (last_bit) begin
          diff_d  = part_shift;
          borr_d  = cell_r;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      diff_q  <= '0;
      borr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      diff_q  <= diff_d;
      borr_q  <= borr_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign Diff = diff_q;
  assign Borr = borr_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: WIDTH=8 and WIDTH=1 instances checked every cycle
// against an arithmetic model, plus directed vectors with hand-computed results.
module tb_serial_subtractor_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       bin8 = 1'b0;
  logic       busy8, done8, borr8;
  logic [7:0] diff8;

  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic busy1, done1, diff1, borr1;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .Diff(diff8), .Borr(borr8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Bin(bin1),
    .busy(busy1), .done(done1), .Diff(diff1), .Borr(borr1)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: result = A - B - Bin in WIDTH+1 bits; top bit is the borrow.
  // phase 0 = idle, 1 = running (left cycles remaining), 2 = done pulse.
  int         m8_phase, m8_left;
  logic [7:0] m8_diff, m8_pd;
  logic       m8_borr, m8_pb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_phase <= 0; m8_left <= 0;
      m8_diff  <= 8'h00; m8_borr <= 1'b0; m8_pd <= 8'h00; m8_pb <= 1'b0;
    end else begin
      case (m8_phase)
        0: if (start8) begin
          {m8_pb, m8_pd} <= {1'b0, a8} - {1'b0, b8} - 9'(bin8);
          m8_left  <= 8;
          m8_phase <= 1;
        end
        1: begin
          m8_left <= m8_left - 1;
          if (m8_left == 1) begin
            m8_diff  <= m8_pd;
            m8_borr  <= m8_pb;
            m8_phase <= 2;
          end
        end
        default: m8_phase <= 0;
      endcase
    end
  end

  int   m1_phase;
  logic m1_diff, m1_pd, m1_borr, m1_pb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_phase <= 0;
      m1_diff  <= 1'b0; m1_borr <= 1'b0; m1_pd <= 1'b0; m1_pb <= 1'b0;
    end else begin
      case (m1_phase)
        0: if (start1) begin
          {m1_pb, m1_pd} <= {1'b0, a1} - {1'b0, b1} - 2'(bin1);
          m1_phase <= 1;
        end
        1: begin
          m1_diff  <= m1_pd;
          m1_borr  <= m1_pb;
          m1_phase <= 2;
        end
        default: m1_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy8", 32'(busy8), 32'(m8_phase == 1));
    check("done8", 32'(done8), 32'(m8_phase == 2));
    check("diff8", 32'(diff8), 32'(m8_diff));
    check("borr8", 32'(borr8), 32'(m8_borr));
    check("busy1", 32'(busy1), 32'(m1_phase == 1));
    check("done1", 32'(done1), 32'(m1_phase == 2));
    check("diff1", 32'(diff1), 32'(m1_diff));
    check("borr1", 32'(borr1), 32'(m1_borr));
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] exp_d, input logic exp_b);
    int nb;
    int got;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0; got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (done8) got = 1;
      else begin
        if (busy8) nb++;
        @(negedge clk);
      end
    end
    check("op_done_seen", 32'(got), 32'd1);
    check("op_busy_cycles", 32'(nb), 32'd8);
    check("op_diff", 32'(diff8), 32'(exp_d));
    check("op_borr", 32'(borr8), 32'(exp_b));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, got, t, d1, d2, ndone;
    logic [7:0] tt_d, tt_b;

    #1 rst_n = 1'b0;
    #1;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_diff8", 32'(diff8), 32'd0);
    check("rst_borr8", 32'(borr8), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
    op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
    op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

    // start held high: second op accepted on the IDLE cycle after done
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b0;
    t = 0; d1 = -1; d2 = -1;
    for (int i = 0; i < 40 && d2 < 0; i++) begin
      @(negedge clk);
      t++;
      if (done8) begin
        if (d1 < 0) d1 = t;
        else begin
          d2 = t;
          start8 = 1'b0;
        end
      end
    end
    start8 = 1'b0;
    check("held_first_done", 32'(d1), 32'd9);
    check("held_period", 32'(d2 - d1), 32'd10);
    check("held_diff", 32'(diff8), 32'h00);

    // start and operands change mid-RUN: ignored, previous result holds
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0; got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      if (done8) got = 1;
      else begin
        if (busy8) nb++;
        check("hold_diff", 32'(diff8), 32'h00);
        if (nb == 3) begin start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1; end
        if (nb == 4) start8 = 1'b0;
        @(negedge clk);
      end
    end
    start8 = 1'b0;
    check("ign_done_seen", 32'(got), 32'd1);
    check("ign_busy_cycles", 32'(nb), 32'd8);
    check("ign_diff", 32'(diff8), 32'h0F);
    check("ign_borr", 32'(borr8), 32'd0);

    // reset in RUN cycle 4 aborts the operation
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_diff", 32'(diff8), 32'h00);
    check("abort_borr", 32'(borr8), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);

    // WIDTH=1: exhaustive {A,B,Bin} against the 1-bit truth table
    tt_d = 8'b1001_0110;
    tt_b = 8'b1000_1110;
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      start1 = 1'b1; {a1, b1, bin1} = 3'(v);
      @(negedge clk);
      start1 = 1'b0;
      check("w1_busy", 32'(busy1), 32'd1);
      check("w1_not_done_yet", 32'(done1), 32'd0);
      @(negedge clk);
      check("w1_done", 32'(done1), 32'd1);
      check("w1_diff", 32'(diff1), 32'(tt_d[v]));
      check("w1_borr", 32'(borr1), 32'(tt_b[v]));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Multi-bit subtractor controller that reuses a single 1-bit full-subtractor cell over WIDTH clock cycles, LSB first.
- Computes A - B - Bin for WIDTH-bit unsigned operands.
- Trades latency for area. Sits between a requester (start/done handshake) and the shared 1-bit subtract datapath.
- Sequences operand bits, carries the borrow between cycles, and assembles the result.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured when start is accepted.
- B  input  WIDTH  subtrahend; captured when start is accepted.
- Bin  input  1  initial borrow-in; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- Diff  output  WIDTH  result register A - B - Bin mod 2^WIDTH.
- Borr  output  1  final borrow-out; 1 when A < B + Bin.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, Diff=0, Borr=0.
  - Internal operand shift registers, bit counter and running borrow are all cleared.
  - Reset asserted mid-operation aborts the operation; no done pulse is produced.
  - Operation resumes on the first rising edge after rst_n deasserts.
- Cell equations, evaluated every RUN cycle on the current LSBs a, b and running borrow r:
  - d = a ^ b ^ r
  - r_next = (~a & b) | (~a & r) | (b & r)
- State IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch A, B into shift registers; running borrow := Bin; counter := 0; go to RUN.
  - start=0 keeps the block in IDLE.
- State RUN:
  - busy=1.
  - Each edge: shift d into the MSB of the partial-result register and shift the operand registers right by one. Running borrow := r_next. Counter increments.
  - On the edge where counter = WIDTH-1, the last bit is consumed:
    - Diff := completed partial-result register (with d of this cycle included).
    - Borr := r_next.
    - Go to DONE.
  - start is ignored in RUN; A/B/Bin changes have no effect.
- State DONE:
  - done=1, busy=0, for exactly one cycle; unconditional return to IDLE.
  - start is ignored in DONE; a requester holding start high is accepted on the IDLE cycle that follows.
- Latency:
  - Start accepted at edge k; busy=1 for cycles k..k+WIDTH-1 after their edges.
  - done=1 in the cycle following edge k+WIDTH.
  - Back-to-back throughput: one result per WIDTH+2 cycles.
- Output holding:
  - Diff/Borr change only at RUN->DONE.
  - They hold the previous result through IDLE and a subsequent RUN until the new result completes.
- WIDTH=1: RUN lasts one cycle; behaves as a registered single-bit full subtractor.
- Counter width is $clog2(WIDTH)+1 so that WIDTH being a power of 2 needs no special case. Counter wrap is never reached.
- Arithmetic is unsigned modulo 2^WIDTH. Borr is the true borrow-out; there is no overflow flag.
- X on start in IDLE is a verification error. The design need not define behaviour for it.

Test Plan:
- WIDTH=8: A=8'h05, B=8'h03, Bin=0, start pulse -> busy high 8 cycles, then done pulse; Diff=8'h02, Borr=0.
- A=8'h03, B=8'h05, Bin=0 -> Diff=8'hFE, Borr=1. A=8'h00, B=8'h00, Bin=1 -> Diff=8'hFF, Borr=1 (full borrow ripple).
- A=8'hFF, B=8'hFF, Bin=0 -> Diff=8'h00, Borr=0. Then start held high continuously -> second operation accepted on the IDLE cycle after done; the result period is 10 cycles.
- Start op A=8'h10, B=8'h01. Toggle start and change A/B at cycle 3 of RUN -> ignored. Result Diff=8'h0F, Borr=0. Previous Diff value holds until done.
- Assert rst_n=0 at RUN cycle 4 -> outputs 0 asynchronously, no done. After release, A=8'h80, B=8'h7F, Bin=1 -> Diff=8'h00, Borr=0.
- WIDTH=1 build: exhaustive 8 combinations of {A,B,Bin} -> Diff/Borr match the 1-bit truth table, done 1 cycle after start acceptance.
